// File: rtl/jk_mod_counter_if.sv
// rtl/jk_mod_counter_if.sv - control/status bundle of the JK modulo-N counter
interface jk_mod_counter_if #(
  parameter int WIDTH = 4
);
  logic             en;
  logic             up;
  logic             load;
  logic [WIDTH-1:0] din;
  logic [WIDTH-1:0] count;
  logic [WIDTH-1:0] j_vec;
  logic [WIDTH-1:0] k_vec;
  logic             tc;

  modport master (
    output en, up, load, din,
    input  count, j_vec, k_vec, tc
  );

  modport slave (
    input  en, up, load, din,
    output count, j_vec, k_vec, tc
  );
endinterface

// File: rtl/jk_mod_counter.sv
// rtl/jk_mod_counter.sv - modulo-N up/down counter built from JK cells and their excitation logic
module jk_mod_counter #(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 10
) (
  input  logic            clk,
  input  logic            rst,
  jk_mod_counter_if.slave bus
);
  localparam logic [WIDTH-1:0] MAX = WIDTH'(MODULUS - 1);

  logic [WIDTH-1:0] count_q;
  logic             tc_q;
  logic [WIDTH-1:0] next_d;
  logic             wrap_d;
  logic [WIDTH-1:0] j_d;
  logic [WIDTH-1:0] k_d;
  logic             over_d;

  // Compared at 32 bits so a full-range MODULUS does not yield a constant compare.
  assign over_d = ({{(32-WIDTH){1'b0}}, bus.din} >= 32'(MODULUS));

  always_comb begin
    next_d = count_q;
    wrap_d = 1'b0;
    if (bus.load) begin
      next_d = over_d ? MAX : bus.din;
    end else if (bus.en) begin
      if (bus.up) begin
        if (count_q == MAX) begin
          next_d = '0;
          wrap_d = 1'b1;
        end else begin
          next_d = count_q + 1'b1;
        end
      end else begin
        if (count_q == '0) begin
          next_d = MAX;
          wrap_d = 1'b1;
        end else begin
          next_d = count_q - 1'b1;
        end
      end
    end
  end

  // Load drives set/clear directly; counting only toggles the bits that change.
  always_comb begin
    j_d = '0;
    k_d = '0;
    if (bus.load) begin
      j_d = next_d;
      k_d = ~next_d;
    end else begin
      j_d = next_d ^ count_q;
      k_d = next_d ^ count_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
      tc_q    <= 1'b0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        case ({j_d[i], k_d[i]})
          2'b00:   count_q[i] <= count_q[i];
          2'b01:   count_q[i] <= 1'b0;
          2'b10:   count_q[i] <= 1'b1;
          default: count_q[i] <= ~count_q[i];
        endcase
      end
      tc_q <= wrap_d;
    end
  end

  assign bus.count = count_q;
  assign bus.tc    = tc_q;
  assign bus.j_vec = j_d;
  assign bus.k_vec = k_d;
endmodule

// File: tb/tb_jk_mod_counter.sv
// tb/tb_jk_mod_counter.sv - directed self-checking bench for jk_mod_counter (MODULUS 10 and 16 builds)
module tb_jk_mod_counter;
  logic clk;
  logic rst;
  int   checks;
  int   errors;

  jk_mod_counter_if #(.WIDTH(4)) b10 ();
  jk_mod_counter_if #(.WIDTH(4)) b16 ();

  jk_mod_counter #(.WIDTH(4), .MODULUS(10)) dut10 (.clk(clk), .rst(rst), .bus(b10.slave));
  jk_mod_counter #(.WIDTH(4), .MODULUS(16)) dut16 (.clk(clk), .rst(rst), .bus(b16.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [3:0] jkf(input logic [3:0] q, input logic [3:0] j, input logic [3:0] k);
    logic [3:0] r;
    for (int i = 0; i < 4; i++) begin
      if (!j[i] && !k[i])     r[i] = q[i];
      else if (!j[i] && k[i]) r[i] = 1'b0;
      else if (j[i] && !k[i]) r[i] = 1'b1;
      else                    r[i] = ~q[i];
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One rising edge; both builds must obey the JK table given the pre-edge excitation.
  task automatic step();
    logic [3:0] p0, j0, k0, p1, j1, k1;
    @(negedge clk);
    p0 = b10.count; j0 = b10.j_vec; k0 = b10.k_vec;
    p1 = b16.count; j1 = b16.j_vec; k1 = b16.k_vec;
    @(posedge clk);
    #1;
    chk("jk_table_m10", {28'd0, b10.count}, {28'd0, jkf(p0, j0, k0)});
    chk("jk_table_m16", {28'd0, b16.count}, {28'd0, jkf(p1, j1, k1)});
  endtask

  int exp2 [12] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2};
  int exp3 [3]  = '{0, 9, 8};
  int tc3  [3]  = '{0, 1, 0};

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b0;
    b10.en = 1'b0; b10.up = 1'b0; b10.load = 1'b0; b10.din = 4'd0;
    b16.en = 1'b0; b16.up = 1'b0; b16.load = 1'b0; b16.din = 4'd0;
    #3;
    chk("reset_count", {28'd0, b10.count}, 32'd0);
    chk("reset_tc", {31'd0, b10.tc}, 32'd0);
    chk("reset_count_m16", {28'd0, b16.count}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;

    // Async reset mid-cycle from count=7
    b10.load = 1'b1; b10.din = 4'd7;
    step();
    chk("load7", {28'd0, b10.count}, 32'd7);
    b10.load = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    chk("async_rst_count", {28'd0, b10.count}, 32'd0);
    chk("async_rst_tc", {31'd0, b10.tc}, 32'd0);
    @(posedge clk);
    #1;
    chk("rst_hold_count", {28'd0, b10.count}, 32'd0);
    rst = 1'b1;

    // Count up 12 edges from 0
    b10.en = 1'b1; b10.up = 1'b1;
    for (int i = 0; i < 12; i++) begin
      if (i == 9) begin
        chk("up_j_at9", {28'd0, b10.j_vec}, 32'h9);
        chk("up_k_at9", {28'd0, b10.k_vec}, 32'h9);
      end
      step();
      chk($sformatf("up_count_%0d", i), {28'd0, b10.count}, 32'(exp2[i]));
      chk($sformatf("up_tc_%0d", i), {31'd0, b10.tc}, (i == 9) ? 32'd1 : 32'd0);
    end

    // Count down from 1 through the wrap
    b10.en = 1'b0; b10.load = 1'b1; b10.din = 4'd1;
    step();
    chk("load1", {28'd0, b10.count}, 32'd1);
    b10.load = 1'b0; b10.en = 1'b1; b10.up = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("dn_count_%0d", i), {28'd0, b10.count}, 32'(exp3[i]));
      chk($sformatf("dn_tc_%0d", i), {31'd0, b10.tc}, 32'(tc3[i]));
    end

    // Load beats enable, and clamps
    b10.load = 1'b1; b10.din = 4'd6;
    #1;
    chk("load6_j", {28'd0, b10.j_vec}, 32'h6);
    chk("load6_k", {28'd0, b10.k_vec}, 32'h9);
    step();
    chk("load6_count", {28'd0, b10.count}, 32'd6);
    chk("load6_tc", {31'd0, b10.tc}, 32'd0);
    b10.din = 4'd13;
    #1;
    chk("load13_j", {28'd0, b10.j_vec}, 32'h9);
    chk("load13_k", {28'd0, b10.k_vec}, 32'h6);
    step();
    chk("load13_clamp", {28'd0, b10.count}, 32'd9);
    b10.up = 1'b1; b10.din = 4'd3;
    step();
    chk("load_over_wrap_count", {28'd0, b10.count}, 32'd3);
    chk("load_over_wrap_tc", {31'd0, b10.tc}, 32'd0);

    // Direction flips with no dead cycle, then hold
    b10.din = 4'd5;
    step();
    chk("load5", {28'd0, b10.count}, 32'd5);
    b10.load = 1'b0; b10.up = 1'b1;
    step();
    chk("dir_up_6", {28'd0, b10.count}, 32'd6);
    b10.up = 1'b0;
    step();
    chk("dir_dn_5", {28'd0, b10.count}, 32'd5);
    b10.up = 1'b1;
    step();
    chk("dir_up_6b", {28'd0, b10.count}, 32'd6);
    b10.en = 1'b0;
    #1;
    chk("hold_j", {28'd0, b10.j_vec}, 32'd0);
    chk("hold_k", {28'd0, b10.k_vec}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("hold_count_%0d", i), {28'd0, b10.count}, 32'd6);
      chk($sformatf("hold_tc_%0d", i), {31'd0, b10.tc}, 32'd0);
    end

    // Full-range build wraps 15 -> 0
    b16.load = 1'b1; b16.din = 4'd14;
    step();
    chk("m16_load14", {28'd0, b16.count}, 32'd14);
    b16.load = 1'b0; b16.en = 1'b1; b16.up = 1'b1;
    step();
    chk("m16_count15", {28'd0, b16.count}, 32'd15);
    chk("m16_tc_pre", {31'd0, b16.tc}, 32'd0);
    #1;
    chk("m16_j_at15", {28'd0, b16.j_vec}, 32'hF);
    chk("m16_k_at15", {28'd0, b16.k_vec}, 32'hF);
    step();
    chk("m16_wrap_count", {28'd0, b16.count}, 32'd0);
    chk("m16_wrap_tc", {31'd0, b16.tc}, 32'd1);
    step();
    chk("m16_after_count", {28'd0, b16.count}, 32'd1);
    chk("m16_after_tc", {31'd0, b16.tc}, 32'd0);
    chk("m10_idle_count", {28'd0, b10.count}, 32'd6);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
